// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module   : div
//  Purpose  : Multi-cycle 32/32 integer divider for DIV/DIVU. Radix-2
//             restoring, one quotient bit per cycle. result_o packs
//             {remainder, quotient} for HI/LO write-back.
//  Revision : 1.0 - initial release
// ============================================================================
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   localparam logic [1:0] S_FREE   = 2'b00;
   localparam logic [1:0] S_BYZERO = 2'b01;
   localparam logic [1:0] S_ON     = 2'b10;
   localparam logic [1:0] S_END    = 2'b11;

   localparam logic [4:0] C_LAST_ITER = 5'd31;

   logic [1:0]  state_q,  state_d;
   logic [4:0]  cnt_q,    cnt_d;
   // Dividend bits shift out of the top while quotient bits shift in at the
   // bottom, so one register serves both roles during iteration.
   logic [31:0] dq_q,     dq_d;
   logic [31:0] dvs_q,    dvs_d;
   logic [31:0] rem_q,    rem_d;
   logic        negq_q,   negq_d;
   logic        negr_q,   negr_d;
   logic [63:0] result_q, result_d;
   logic        ready_q,  ready_d;

   logic [31:0] w_abs1;
   logic [31:0] w_abs2;
   logic [32:0] w_trial;
   logic [31:0] w_rem_step;
   logic [31:0] w_quot_step;

   // Operand magnitudes and one restoring-division step.
   always_comb begin
      w_abs1      = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      w_abs2      = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
      w_trial     = {rem_q, dq_q[31]} - {1'b0, dvs_q};
      // Partial remainder is always below the divisor, so a negative trial
      // means the shifted remainder still fits in 32 bits.
      w_rem_step  = w_trial[32] ? {rem_q[30:0], dq_q[31]} : w_trial[31:0];
      w_quot_step = {dq_q[30:0], ~w_trial[32]};
   end

   // Next-state logic; annul has priority over every other transition.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dq_d     = dq_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;

      if (annul_i) begin
         state_d  = S_FREE;
         ready_d  = 1'b0;
         result_d = 64'd0;
      end else begin
         case (state_q)
            S_FREE: begin
               ready_d  = 1'b0;
               result_d = 64'd0;
               if (start_i) begin
                  if (opdata2_i == 32'd0) begin
                     state_d = S_BYZERO;
                  end else begin
                     state_d = S_ON;
                     dq_d    = w_abs1;
                     dvs_d   = w_abs2;
                     rem_d   = 32'd0;
                     cnt_d   = 5'd0;
                     negq_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                     negr_d  = signed_div_i & opdata1_i[31];
                  end
               end
            end
            S_BYZERO: begin
               state_d = S_END;
               dq_d    = 32'd0;
               rem_d   = 32'd0;
            end
            S_ON: begin
               cnt_d = cnt_q + 5'd1;
               dq_d  = w_quot_step;
               rem_d = w_rem_step;
               if (cnt_q == C_LAST_ITER) begin
                  // Sign fix-up applied on the final iteration edge.
                  state_d = S_END;
                  dq_d    = negq_q ? (~w_quot_step + 32'd1) : w_quot_step;
                  rem_d   = negr_q ? (~w_rem_step + 32'd1) : w_rem_step;
               end
            end
            S_END: begin
               if (start_i) begin
                  ready_d  = 1'b1;
                  result_d = {rem_q, dq_q};
               end else begin
                  state_d  = S_FREE;
                  ready_d  = 1'b0;
                  result_d = 64'd0;
               end
            end
            default: begin
               state_d  = S_FREE;
               ready_d  = 1'b0;
               result_d = 64'd0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FREE;
         cnt_q    <= 5'd0;
         dq_q     <= 32'd0;
         dvs_q    <= 32'd0;
         rem_q    <= 32'd0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= 64'd0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dq_q     <= dq_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div
//  Purpose  : Directed self-checking bench for the div block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_errors = 0;

   div u_dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch a division, measure edges until ready, verify hold and release.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
      int lat;
      lat = -1;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(posedge clk);
         #1;
         if (ready_o) lat = k;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, result_o, exp);
      // start held through END must not restart
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check({tag, " hold ready"}, 64'(ready_o), 64'd1);
      check({tag, " hold result"}, result_o, exp);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " release ready"}, 64'(ready_o), 64'd0);
      check({tag, " release result"}, result_o, 64'd0);
   endtask

   initial begin
      int seen;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_div("u100/7",   1'b0, 32'd100,       32'd7,          {32'd2, 32'd14}, 33);
      do_div("s-7/2",    1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
      do_div("s7/-2",    1'b1, 32'd7,         32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33);
      do_div("u/0",      1'b0, 32'h1234,      32'd0,          64'd0, 2);
      do_div("s/0",      1'b1, 32'h1234,      32'd0,          64'd0, 2);
      do_div("s ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'd0, 32'h80000000}, 33);
      do_div("u max/1",  1'b0, 32'hFFFFFFFF,  32'd1,          {32'd0, 32'hFFFFFFFF}, 33);

      // Abort at ON iteration 10; ready must never assert.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      check("annul ready", 64'(ready_o), 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready_o) seen++;
      end
      check("annul no ready", 64'(seen), 64'd0);
      do_div("u20/3 after annul", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);

      // Operand changes while in ON are ignored.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd9;
      start_i      = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      signed_div_i = 1'b1;
      opdata1_i    = 32'd5;
      opdata2_i    = 32'hFFFFFFFF;
      seen = -1;
      for (int k = 6; k < 40 && seen < 0; k++) begin
         @(posedge clk);
         #1;
         if (ready_o) seen = k;
      end
      check("mutate latency", 64'(seen), 64'd33);
      check("mutate result", result_o, {32'd1, 32'd111});

      // Reset while result is presented clears outputs.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst END ready", 64'(ready_o), 64'd0);
      check("rst END result", result_o, 64'd0);
      @(negedge clk);
      rst     = 1'b0;
      start_i = 1'b0;
      @(posedge clk);

      // Reset mid-ON: in-flight division is lost.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd50;
      opdata2_i    = 32'd5;
      start_i      = 1'b1;
      repeat (16) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst ON ready", 64'(ready_o), 64'd0);
      check("rst ON result", result_o, 64'd0);
      @(negedge clk);
      rst     = 1'b0;
      start_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready_o) seen++;
      end
      check("rst ON no ready", 64'(seen), 64'd0);

      do_div("u50/5 after rst", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
